sdram_ctrl_emu: RTL
===================

Name: sdram_ctrl_emu

Overview:
On-chip-RAM-backed responder for the SDRAM controller user port (wr/rd req, addr, burst_len, ack, data). It replaces the SDRAM controller so that the FIFO-side initiator and the multi-port arbitration logic can be verified and brought up without external SDRAM. It is cycle-compatible with the controller's user handshake, models the init delay, and stores data in an inferred dual-port RAM.

Parameters:
DATA_W, 16, width of data_in/data_out
ADDR_W, 24, width of user word addresses
MEM_AW, 10, RAM depth 2^MEM_AW words; the low MEM_AW address bits are used
INIT_CYCLES, 200, cycles after reset before init_end rises
GAP_CYCLES, 2, idle cycles forced after every burst (min 1)
REF_PERIOD, 780, refresh interval in cycles (EMU_REFRESH_EN only)
REF_CYCLES, 7, refresh blackout length (EMU_REFRESH_EN only)

Ports:
sys_clk  in  1  sole clock
sys_rst_n  in  1  asynchronous active-low reset
sdram_wr_req  in  1  write request, held until first ack cycle
sdram_wr_addr  in  ADDR_W  write start address, sampled at grant
wr_burst_len  in  10  write words, sampled at grant
sdram_data_in  in  DATA_W  write data, valid in every write-ack cycle
sdram_wr_ack  out  1  high exactly once per accepted write word
sdram_rd_req  in  1  read request, held until first ack cycle
sdram_rd_addr  in  ADDR_W  read start address, sampled at grant
rd_burst_len  in  10  read words, sampled at grant
sdram_data_out  out  DATA_W  read data, valid in every read-ack cycle
sdram_rd_ack  out  1  high exactly once per delivered read word
init_end  out  1  emulated init complete

Behaviour:
- Reset values: wr_ack=0, rd_ack=0, data_out=0, init_end=0, state=INIT. The RAM is never cleared.
- States: INIT, IDLE, WR, RD_PRE, RD, GAP.
- INIT: a counter runs to INIT_CYCLES-1. Then init_end is registered to 1, stays at 1 until reset, and the state goes to IDLE. Requests are ignored in INIT.
- IDLE, grant: wr_req has priority over rd_req when both are high. On grant, latch addr[MEM_AW-1:0] and len. len=0 is treated as 1.
- WR: wr_ack=1 for exactly len consecutive cycles, starting the cycle after grant. In each ack cycle, data_in is written to RAM[ptr] and ptr increments. After the last word, go to GAP.
- RD_PRE: lasts 1 cycle and issues the RAM read of ptr.
- RD: rd_ack=1 for exactly len consecutive cycles, with data_out (registered) aligned to rd_ack. Read latency is 2 cycles from grant to the first ack/data. After the last word, go to GAP. data_out holds its last value outside ack cycles.
- GAP: GAP_CYCLES idle cycles with both acks at 0, then IDLE. A request still high in GAP is granted only from IDLE.
- Address wrap: ptr is MEM_AW bits and wraps modulo 2^MEM_AW inside a burst (1023 -> 0). Upper address bits are ignored, so aliasing is intended.
- Write and read acks are never high in the same cycle.
- Req dropped before grant: no burst occurs. Req dropped mid-burst: the burst still completes its full len.
- Read-after-write to the same address returns the new data, because the write has completed before RD_PRE.
- Async reset mid-burst: acks drop immediately and the state returns to INIT. The RAM keeps any words already written.

Optional Feature:
Macro EMU_REFRESH_EN.
- Defined: a free-running counter (started at init_end) raises a refresh pending flag every REF_PERIOD cycles. A pending refresh is taken from IDLE before any grant, through a REF state lasting REF_CYCLES with no acks, and then returns to IDLE. An active burst is never interrupted; the refresh waits until after GAP.
- Not defined: there is no REF state and no refresh counter, and grants are limited only by GAP.

Test Plan:
- Reset release -> init_end=0 through cycle 199 and 1 from cycle 200. Req before that gets no ack.
- Write addr 0x000010, len 4, data 0xA0..0xA3 -> wr_ack high for 4 cycles starting 1 after grant. Then read 0x000010 len 4 -> rd_ack high 4 cycles starting 2 after grant, data 0xA0,0xA1,0xA2,0xA3.
- wr_req and rd_req rise together -> write served first, 2 gap cycles, then read. Acks never overlap.
- Write addr 0x0003FE, len 4 -> words land at 0x3FE,0x3FF,0x000,0x001. Read addr 0x000400 len 2 returns the words from 0x000 and 0x001.
- len=0 write -> exactly 1 ack. Reset asserted in the 3rd ack cycle of a len 8 write -> ack 0 immediately, init_end 0, first 2 words readable after re-init.
- EMU_REFRESH_EN, REF_PERIOD=780 -> a request pending when refresh fires is acked only after 7 blackout cycles. A len 64 burst spanning the refresh point is not split.

Source files
------------

// File: rtl/sdram_ctrl_emu_if.sv
// User-port bundle of the SDRAM controller: write/read request channels, acks, data and init status.
interface sdram_ctrl_emu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [9:0]        wr_burst_len;
  logic [DATA_W-1:0] sdram_data_in;
  logic              sdram_wr_ack;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [9:0]        rd_burst_len;
  logic [DATA_W-1:0] sdram_data_out;
  logic              sdram_rd_ack;
  logic              init_end;

  modport master (
    output sdram_wr_req, sdram_wr_addr, wr_burst_len, sdram_data_in,
    output sdram_rd_req, sdram_rd_addr, rd_burst_len,
    input  sdram_wr_ack, sdram_rd_ack, sdram_data_out, init_end
  );

  modport slave (
    input  sdram_wr_req, sdram_wr_addr, wr_burst_len, sdram_data_in,
    input  sdram_rd_req, sdram_rd_addr, rd_burst_len,
    output sdram_wr_ack, sdram_rd_ack, sdram_data_out, init_end
  );
endinterface

// File: rtl/sdram_ctrl_emu.sv
// RAM-backed stand-in for the SDRAM controller user port (init delay, burst acks, post-burst gap).
// Optional periodic refresh blackout is enabled with the EMU_REFRESH_EN macro.
module sdram_ctrl_emu #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 24,
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 200,
  parameter int GAP_CYCLES  = 2,
  parameter int REF_PERIOD  = 780,
  parameter int REF_CYCLES  = 7
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  sdram_ctrl_emu_if.slave bus
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [9:0]    GAP_LAST  = 10'((GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR, S_RD_PRE, S_RD, S_GAP
`ifdef EMU_REFRESH_EN
    , S_REF
`endif
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [IW-1:0]     init_cnt;
  logic              init_end;
  logic [9:0]        cnt, len_m1, len_sel;
  logic [MEM_AW-1:0] ptr;
  logic [DATA_W-1:0] data_out;
  logic              wr_ack, rd_ack, last;
  logic              ref_pend;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.sdram_wr_addr[ADDR_W-1:MEM_AW], bus.sdram_rd_addr[ADDR_W-1:MEM_AW]};

`ifdef EMU_REFRESH_EN
  localparam int RW = $clog2(REF_PERIOD + 1);
  localparam logic [RW-1:0] REF_P_LAST = RW'(REF_PERIOD - 1);
  localparam logic [9:0]    REF_LAST   = 10'((REF_CYCLES < 1) ? 0 : REF_CYCLES - 1);
  logic [RW-1:0] ref_cnt;

  // Pending flag is cleared when taken from IDLE; a new period tick wins over the clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      if (state == S_IDLE && ref_pend) ref_pend <= 1'b0;
      if (init_end) begin
        if (ref_cnt == REF_P_LAST) begin
          ref_cnt  <= '0;
          ref_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + RW'(1);
        end
      end
    end
  end
`else
  localparam int unused_ref_params = REF_PERIOD + REF_CYCLES;
  assign ref_pend = 1'b0;
`endif

  assign len_sel = bus.sdram_wr_req ? bus.wr_burst_len : bus.rd_burst_len;
  assign last    = (cnt == len_m1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_INIT;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_ack   = 1'b0;
    rd_ack   = 1'b0;
    unique case (state)
      S_INIT:   if (init_cnt == INIT_LAST) state_nx = S_IDLE;
      S_IDLE: begin
        if (ref_pend) begin
`ifdef EMU_REFRESH_EN
          state_nx = S_REF;
`endif
        end else if (bus.sdram_wr_req) state_nx = S_WR;
        else if (bus.sdram_rd_req)     state_nx = S_RD_PRE;
      end
      S_WR: begin
        wr_ack = 1'b1;
        if (last) state_nx = S_GAP;
      end
      S_RD_PRE: state_nx = S_RD;
      S_RD: begin
        rd_ack = 1'b1;
        if (last) state_nx = S_GAP;
      end
      S_GAP:    if (cnt == GAP_LAST) state_nx = S_IDLE;
`ifdef EMU_REFRESH_EN
      S_REF:    if (cnt == REF_LAST) state_nx = S_IDLE;
`endif
      default:  state_nx = S_INIT;
    endcase
  end

  // RAM array carries no reset so contents survive a mid-burst reset.
  always_ff @(posedge sys_clk) begin
    if (state == S_WR) mem[ptr] <= bus.sdram_data_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      init_cnt <= '0;
      init_end <= 1'b0;
      cnt      <= '0;
      len_m1   <= '0;
      ptr      <= '0;
      data_out <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) init_end <= 1'b1;
          else                       init_cnt <= init_cnt + IW'(1);
        end
        S_IDLE: begin
          cnt    <= '0;
          ptr    <= bus.sdram_wr_req ? bus.sdram_wr_addr[MEM_AW-1:0] : bus.sdram_rd_addr[MEM_AW-1:0];
          len_m1 <= (len_sel == 10'd0) ? 10'd0 : len_sel - 10'd1;
        end
        S_WR: begin
          ptr <= ptr + MEM_AW'(1);
          cnt <= last ? 10'd0 : cnt + 10'd1;
        end
        // Pre-read word 0 so data_out lines up with the first rd_ack.
        S_RD_PRE: begin
          data_out <= mem[ptr];
          ptr      <= ptr + MEM_AW'(1);
        end
        S_RD: begin
          if (last) begin
            cnt <= 10'd0;
          end else begin
            data_out <= mem[ptr];
            ptr      <= ptr + MEM_AW'(1);
            cnt      <= cnt + 10'd1;
          end
        end
        default: cnt <= cnt + 10'd1;
      endcase
    end
  end

  assign bus.sdram_wr_ack   = wr_ack;
  assign bus.sdram_rd_ack   = rd_ack;
  assign bus.sdram_data_out = data_out;
  assign bus.init_end       = init_end;

endmodule
